// File: rtl/bmem_pkg.sv
// Shared types and constants for the two-port memory-controller arbiter.
package bmem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DROP,
        WAIT_RISE,
        READ_BEATS,
        DONE
    } state_t;

    localparam int ICACHE_PORT = 0;
    localparam int DCACHE_PORT = 1;
    localparam int BEATS       = 4;

endpackage

// File: rtl/bmem_arb_pick.sv
// Combinational grant picker: a lone requester wins; on a tie the port that
// did not win last is chosen (tie last=0 to get fixed dcache priority).
module bmem_arb_pick
    import bmem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner
);

    always_comb begin
        if (req[ICACHE_PORT] && req[DCACHE_PORT]) begin
            winner = ~last;
        end else begin
            winner = req[DCACHE_PORT];
        end
    end

endmodule

// File: rtl/bmem_arbiter.sv
// Shares one memory controller between icache (port 0) and dcache (port 1).
// Define BMEM_ARB_RR_EN for round-robin ties; otherwise dcache wins ties.
module bmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int BEATS  = bmem_pkg::BEATS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] req_addr [2],
    input  logic [1:0]        req_read,
    input  logic [1:0]        req_write,
    input  logic [DATA_W-1:0] req_wdata [2],
    output logic [1:0]        req_ready,
    output logic [DATA_W-1:0] req_rdata,
    output logic [ADDR_W-1:0] req_raddr,
    output logic [1:0]        req_rvalid,
    output logic [1:0]        req_wburst,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic              mem_wburst,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [ADDR_W-1:0] mem_raddr
);

    import bmem_pkg::*;

    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    state_t     state;
    logic       owner;
    logic       op_read;
    logic       last_win;
    logic       grant;
    logic [1:0] beat_cnt;
    logic [1:0] req_any;
    logic       beat_ok;
    logic       wr_busy;

    assign req_any = req_read | req_write;

`ifdef BMEM_ARB_RR_EN
    // Resetting to port 1 hands the very first tie to the icache.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_win <= 1'b1;
        end else if (state == IDLE && |req_any) begin
            last_win <= grant;
        end
    end
`else
    assign last_win = 1'b0;
`endif

    bmem_arb_pick u_pick (
        .req    (req_any),
        .last   (last_win),
        .winner (grant)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= 1'b0;
            op_read   <= 1'b0;
            beat_cnt  <= 2'd0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            req_ready <= 2'b00;
        end else begin
            req_ready <= 2'b00;
            case (state)
                IDLE: begin
                    // Read wins when a port raises both strobes.
                    if (|req_any) begin
                        owner     <= grant;
                        op_read   <= req_read[grant];
                        mem_addr  <= req_addr[grant];
                        mem_read  <= req_read[grant];
                        mem_write <= ~req_read[grant];
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        state <= op_read ? READ_BEATS : WAIT_DROP;
                    end
                end
                READ_BEATS: begin
                    if (mem_rvalid) begin
                        beat_cnt <= beat_cnt + 2'd1;
                        if (beat_cnt == LAST_BEAT) begin
                            mem_read         <= 1'b0;
                            req_ready[owner] <= 1'b1;
                            state            <= DONE;
                        end
                    end
                end
                WAIT_DROP: begin
                    if (!mem_ready) begin
                        state <= WAIT_RISE;
                    end
                end
                WAIT_RISE: begin
                    if (mem_ready) begin
                        mem_write        <= 1'b0;
                        req_ready[owner] <= 1'b1;
                        state            <= DONE;
                    end
                end
                DONE: begin
                    owner    <= 1'b0;
                    beat_cnt <= 2'd0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Steering back to the owner is combinational so beats see no added latency.
    assign beat_ok = (state == READ_BEATS) && mem_rvalid;
    assign wr_busy = !op_read &&
                     (state == ISSUE || state == WAIT_DROP || state == WAIT_RISE);

    always_comb begin
        req_rvalid        = 2'b00;
        req_wburst        = 2'b00;
        req_rvalid[owner] = beat_ok;
        req_wburst[owner] = wr_busy & mem_wburst;
    end

    assign mem_wdata = req_wdata[owner];
    assign req_rdata = mem_rdata;
    assign req_raddr = mem_raddr;

endmodule
